// File: rtl/checkers_row_bus_master.sv
// Avalon-MM master for the checkers row PIO slaves. A scan reads every row's data
// register into a local cache; a write request updates a single row's data register.
module checkers_row_bus_master #(
    parameter int unsigned          NUM_ROWS   = 8,
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = '0,
    parameter int unsigned          ROW_STRIDE = 16,
    localparam int unsigned         ROW_W      = $clog2(NUM_ROWS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_start,
    input  logic              wr_start,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    input  logic [ROW_W-1:0]  row_rd_sel,
    output logic [31:0]       row_rd_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_e;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_e            state_q;
    logic [ROW_W-1:0]  row_q;
    logic              read_q;
    logic              write_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       cache_q [NUM_ROWS];

    // Row address wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] row);
        return BASE_ADDR + ADDR_W'(row) * ADDR_W'(ROW_STRIDE);
    endfunction

    // Bus outputs are driven straight from registers, set on the transition into each state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            // NOTE: the cache is deliberately reset so a reset board never reads stale rows;
            // this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < int'(NUM_ROWS); i++) begin
                cache_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        row_q   <= '0;
                        addr_q  <= row_addr('0);
                        read_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RD_REQ;
                    end else if (wr_start) begin
                        addr_q  <= row_addr(wr_row);
                        wdata_q <= wr_data;
                        write_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cache_q[row_q] <= avm_readdata;
                    if (row_q == LAST_ROW) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        row_q   <= row_q + 1'b1;
                        addr_q  <= row_addr(row_q + 1'b1);
                        read_q  <= 1'b1;
                        state_q <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        write_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
    assign row_rd_data    = cache_q[row_rd_sel];

endmodule

// File: tb/tb_checkers_row_bus_master.sv
// Randomized bench for checkers_row_bus_master: a latency-1 Avalon slave with
// programmable stalls, a row-memory/cache reference model and a bus protocol monitor.
module tb_checkers_row_bus_master;

    localparam int          NUM_ROWS   = 8;
    localparam int          ADDR_W     = 32;
    localparam int          ROW_W      = 3;
    localparam logic [31:0] BASE_ADDR  = 32'h0;
    localparam logic [31:0] ROW_STRIDE = 32'd16;
    localparam int          LIMIT      = 200;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              scan_start = 1'b0;
    logic              wr_start = 1'b0;
    logic [ROW_W-1:0]  wr_row = '0;
    logic [31:0]       wr_data = '0;
    logic              busy;
    logic              done;
    logic [ROW_W-1:0]  row_rd_sel = '0;
    logic [31:0]       row_rd_data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    checkers_row_bus_master dut (
        .clk(clk), .reset_n(reset_n), .scan_start(scan_start), .wr_start(wr_start),
        .wr_row(wr_row), .wr_data(wr_data), .busy(busy), .done(done),
        .row_rd_sel(row_rd_sel), .row_rd_data(row_rd_data),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: what each slave holds, and what the cache should hold.
    logic [31:0] model_mem [NUM_ROWS];
    logic [31:0] exp_cache [NUM_ROWS];

    // Slave model.
    logic [31:0] slave_out   [NUM_ROWS];
    logic [31:0] preload_val [NUM_ROWS];
    logic        preload_en = 1'b0;
    int          rd_stall [NUM_ROWS];
    int          wr_stall = 0;
    int          wait_cnt = 0;
    int          cur_stall;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t log_q[$];

    function automatic int addr_row(input logic [31:0] a);
        logic [31:0] r;
        r = (a - BASE_ADDR) / ROW_STRIDE;
        return int'(r % NUM_ROWS);
    endfunction

    always_comb begin
        cur_stall = avm_write ? wr_stall : rd_stall[addr_row(avm_address)];
        avm_waitrequest = (avm_read || avm_write) && (wait_cnt < cur_stall);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 0;
        end else begin
            if (preload_en) begin
                for (int i = 0; i < NUM_ROWS; i++) slave_out[i] <= preload_val[i];
            end
            avm_readdata <= $urandom;
            if ((avm_read || avm_write) && avm_waitrequest) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (avm_read && !avm_waitrequest) begin
                avm_readdata <= slave_out[addr_row(avm_address)];
                log_q.push_back('{1'b0, avm_address, slave_out[addr_row(avm_address)]});
            end
            if (avm_write && !avm_waitrequest) begin
                slave_out[addr_row(avm_address)] <= avm_writedata;
                log_q.push_back('{1'b1, avm_address, avm_writedata});
            end
        end
    end

    // Protocol monitor: no read/write overlap, requests held stable through stalls.
    logic        p_rd = 1'b0, p_wr = 1'b0, p_wait = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            p_wait = 1'b0;
        end else begin
            if (avm_read || avm_write || p_wait) begin
                n_total++;
                if (avm_read && avm_write)
                    $display("FAIL bus_overlap: read=%b write=%b, required never both", avm_read, avm_write);
                else if (avm_byteenable !== 4'hF)
                    $display("FAIL byteenable: got %h expected f", avm_byteenable);
                else if (p_wait && (avm_read !== p_rd || avm_write !== p_wr || avm_address !== p_addr
                                    || (p_wr && avm_writedata !== p_wdata)))
                    $display("FAIL stall_stable: rd/wr/addr/data %b%b/%h/%h expected %b%b/%h/%h",
                             avm_read, avm_write, avm_address, avm_writedata, p_rd, p_wr, p_addr, p_wdata);
                else n_pass++;
            end
            p_rd = avm_read; p_wr = avm_write; p_addr = avm_address;
            p_wdata = avm_writedata; p_wait = avm_waitrequest;
        end
    end

    task automatic do_preload();
        @(negedge clk);
        preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
        for (int i = 0; i < NUM_ROWS; i++) model_mem[i] = preload_val[i];
    endtask

    // Launch one request and watch done/busy; mid_wr > 0 pulses wr_start that many cycles in.
    task automatic run_op(input bit scan, input bit wr, input logic [ROW_W-1:0] row,
                          input logic [31:0] data, input int mid_wr,
                          output int done_at, output int n_done, output int req_cycles);
        bit busy_ok = 1'b1;
        done_at = -1; n_done = 0; req_cycles = 0;
        @(negedge clk);
        scan_start = scan; wr_start = wr; wr_row = row; wr_data = data;
        for (int i = 1; i <= LIMIT; i++) begin
            @(negedge clk);
            scan_start = 1'b0;
            wr_start = (i == mid_wr);
            if (wr_start) begin
                wr_row = ROW_W'($urandom_range(NUM_ROWS - 1));
                wr_data = $urandom;
            end
            if (avm_read || avm_write) req_cycles++;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = i;
            end
            if ((done_at < 0 || i == done_at) && busy !== 1'b1) busy_ok = 1'b0;
            if (done_at >= 0 && i > done_at && busy !== 1'b0) busy_ok = 1'b0;
            if (done_at >= 0 && i >= done_at + 3) break;
        end
        wr_start = 1'b0;
        n_total++;
        if (!busy_ok) $display("FAIL busy_window: busy not high exactly from cycle 1 to done (done at %0d)", done_at);
        else n_pass++;
    endtask

    task automatic check_cache(input string tag);
        for (int s = 0; s < NUM_ROWS; s++) begin
            row_rd_sel = ROW_W'(s);
            #1;
            n_total++;
            if (row_rd_data !== exp_cache[s])
                $display("FAIL %s_cache[%0d]: got %h expected %h", tag, s, row_rd_data, exp_cache[s]);
            else n_pass++;
        end
    endtask

    task automatic check_scan_log(input string tag, input int base);
        bit ok = (log_q.size() - base) == NUM_ROWS;
        for (int k = 0; ok && k < NUM_ROWS; k++) begin
            if (log_q[base + k].is_wr || log_q[base + k].addr !== BASE_ADDR + ROW_STRIDE * k) ok = 1'b0;
        end
        n_total++;
        if (!ok) $display("FAIL %s_bus_seq: %0d transactions, required %0d reads at rising row addresses",
                          tag, log_q.size() - base, NUM_ROWS);
        else n_pass++;
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // Full scan with the current stall table; cache must end equal to slave contents.
    task automatic scan_and_check(input string tag);
        int done_at, n_done, req_cycles, base, sum_stall;
        sum_stall = 0;
        for (int i = 0; i < NUM_ROWS; i++) sum_stall += rd_stall[i];
        base = log_q.size();
        run_op(1'b1, 1'b0, '0, '0, 0, done_at, n_done, req_cycles);
        for (int i = 0; i < NUM_ROWS; i++) exp_cache[i] = model_mem[i];
        check_int({tag, "_done_cycle"}, done_at, 2 * NUM_ROWS + 1 + sum_stall);
        check_int({tag, "_done_pulses"}, n_done, 1);
        check_int({tag, "_read_cycles"}, req_cycles, NUM_ROWS + sum_stall);
        check_scan_log(tag, base);
        check_cache(tag);
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_ROWS; i++) begin
            rd_stall[i] = 0;
            exp_cache[i] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({avm_read, avm_write, busy, done} !== 4'b0000 || avm_address !== BASE_ADDR || avm_writedata !== '0)
            $display("FAIL reset_outputs: rd/wr/busy/done=%b addr=%h wdata=%h, required 0000/%h/0",
                     {avm_read, avm_write, busy, done}, avm_address, avm_writedata, BASE_ADDR);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        check_int("reset_idle_busy", int'(busy), 0);
        check_cache("reset");
    endtask

    task automatic test_scan_basic();
        for (int r = 0; r < NUM_ROWS; r++) preload_val[r] = 32'h1000_0000 + r;
        do_preload();
        scan_and_check("scan_basic");
        row_rd_sel = 3'd5;
        #1;
        n_total++;
        if (row_rd_data !== 32'h1000_0005) $display("FAIL scan_sel5: got %h expected 10000005", row_rd_data);
        else n_pass++;
    endtask

    task automatic test_scan_stall();
        for (int r = 0; r < NUM_ROWS; r++) preload_val[r] = $urandom;
        do_preload();
        rd_stall[2] = 3;
        scan_and_check("scan_stall_row2");
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                preload_val[r] = $urandom;
                rd_stall[r] = $urandom_range(3);
            end
            do_preload();
            scan_and_check("scan_rand");
        end
        for (int r = 0; r < NUM_ROWS; r++) rd_stall[r] = 0;
    endtask

    task automatic write_and_check(input string tag, input logic [ROW_W-1:0] row, input logic [31:0] data);
        int done_at, n_done, req_cycles, base;
        base = log_q.size();
        run_op(1'b0, 1'b1, row, data, 0, done_at, n_done, req_cycles);
        model_mem[row] = data;
        check_int({tag, "_done_cycle"}, done_at, 2 + wr_stall);
        check_int({tag, "_done_pulses"}, n_done, 1);
        check_int({tag, "_write_cycles"}, req_cycles, 1 + wr_stall);
        n_total++;
        if (log_q.size() != base + 1 || !log_q[base].is_wr
            || log_q[base].addr !== BASE_ADDR + ROW_STRIDE * row || log_q[base].data !== data)
            $display("FAIL %s_bus: %0d transactions, required one write of %h at %h",
                     tag, log_q.size() - base, data, BASE_ADDR + ROW_STRIDE * row);
        else n_pass++;
        n_total++;
        if (slave_out[row] !== data) $display("FAIL %s_out_port: got %h expected %h", tag, slave_out[row], data);
        else n_pass++;
    endtask

    task automatic test_write();
        wr_stall = 0;
        write_and_check("write_row5", 3'd5, 32'hDEAD_BEEF);
        for (int it = 0; it < 4; it++) begin
            wr_stall = $urandom_range(3);
            write_and_check("write_rand", ROW_W'($urandom_range(NUM_ROWS - 1)), $urandom);
        end
        wr_stall = 0;
        check_cache("write_no_cache_effect");
        scan_and_check("scan_after_writes");
    endtask

    task automatic test_collision();
        int done_at, n_done, req_cycles, base, n_wr;
        base = log_q.size();
        run_op(1'b1, 1'b1, 3'd1, 32'hBAD0_0001, 5, done_at, n_done, req_cycles);
        n_wr = 0;
        for (int k = base; k < log_q.size(); k++) if (log_q[k].is_wr) n_wr++;
        for (int i = 0; i < NUM_ROWS; i++) exp_cache[i] = model_mem[i];
        check_int("collision_writes", n_wr, 0);
        check_int("collision_done_cycle", done_at, 2 * NUM_ROWS + 1);
        check_int("collision_done_pulses", n_done, 1);
        check_scan_log("collision", base);
        check_cache("collision");
    endtask

    task automatic test_reset_mid();
        int base, n_rd;
        bit reached = 1'b0;
        base = log_q.size();
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            n_rd = 0;
            for (int k = base; k < log_q.size(); k++) if (!log_q[k].is_wr) n_rd++;
            if (n_rd >= 5) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_int("reset_mid_reached_row4", int'(reached), 1);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_ROWS; i++) exp_cache[i] = '0;
        n_total++;
        if ({avm_read, avm_write, busy, done} !== 4'b0000 || avm_address !== BASE_ADDR)
            $display("FAIL reset_mid_outputs: rd/wr/busy/done=%b addr=%h, required 0000/%h",
                     {avm_read, avm_write, busy, done}, avm_address, BASE_ADDR);
        else n_pass++;
        check_cache("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        scan_and_check("scan_after_reset");
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_scan_stall();
        test_write();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
